ram_arbiter_2p: RTL
===================

// Module: ram_arbiter_2p
// PURPOSE
// - Two-requester arbiter/sequencer in front of the 4-word single-port RAM.
// - Shares the RAM's single wr/rd/add/data_in port between requester 0 and 1.
// - Runs one access at a time, registers read data, and acks each requester with a one-cycle pulse.
// - Sits between two client FSMs and the RAM instance; it is the only driver of the RAM port.
// PARAMETERS
// - DATA_W  4  data word width (matches RAM data_in/data_out)
// - ADDR_W  3  address width (matches RAM add)
// - DEPTH   4  number of implemented RAM words; legal addresses 0..DEPTH-1
// PORTS
// - clk            in   1       single clock, all state on posedge
// - rst_n          in   1       asynchronous, active-low reset
// - req0/req1      in   1       access request; held high until ack
// - we0/we1        in   1       1=write, 0=read; stable while req high
// - addr0/addr1    in   ADDR_W  word address; stable while req high
// - wdata0/wdata1  in   DATA_W  write data; stable while req high
// - ack0/ack1      out  1       one-cycle completion pulse
// - err0/err1      out  1       pulses with ack when addr >= DEPTH
// - rdata0/rdata1  out  DATA_W  read result; valid from ack, held until that port's next read completes
// - mem_wr         out  1       to RAM wr
// - mem_rd         out  1       to RAM rd
// - mem_add        out  ADDR_W  to RAM add
// - mem_din        out  DATA_W  to RAM data_in
// - mem_dout       in   DATA_W  from RAM data_out
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE; all outputs 0; rdata0/1=0.
//   - last_gnt=1, so port 0 wins the first tie.
// - FSM IDLE -> SERVE -> DONE -> IDLE; one access per 3 cycles max.
// - IDLE:
//   - If no req, stay in IDLE.
//   - If exactly one req, grant it.
//   - If both req, grant the port != last_gnt (round-robin).
//   - Latch gnt, we, addr, wdata into registers; go to SERVE.
// - SERVE:
//   - mem_add/mem_din driven from the latched registers.
//   - Write: mem_wr=1, so the RAM commits at the closing edge.
//   - Read: mem_rd=1; mem_dout is captured into rdata[gnt] at the closing edge.
//   - Out-of-range addr (>= DEPTH): mem_wr=mem_rd=0; no RAM access; rdata unchanged.
//   - Go to DONE.
// - DONE:
//   - ack[gnt]=1 for exactly this cycle; err[gnt]=1 here if the addr was out of range.
//   - last_gnt<=gnt; go to IDLE.
// - Latency: req sampled in IDLE at cycle N -> ack high in cycle N+2.
// - Outside SERVE: mem_wr=mem_rd=0 (RAM output tristated); mem_add/mem_din hold their last value.
// - Requester rule: drop req (or present a new op) in the cycle after ack. IDLE re-samples req fresh.
// - req dropped before ack: the access still completes and ack still pulses.
// - Request changes while not granted: ignored until the next IDLE sample.
// - ack0 and ack1 are never high together; mem_wr and mem_rd are never high together.
// - Reset mid-SERVE: a write is not committed unless its edge precedes rst_n falling; no ack is issued.
// CONFIGURATION
// - RAM_ARB_FIXED_PRIO_EN defined:
//   - Fixed priority; port 0 always wins a tie.
//   - last_gnt is not used.
// - Not defined (default):
//   - Round-robin as above.
//   - Port 1 is never starved by continuous port 0 traffic.
// TESTING
// - Single write: req0, we0=1, addr0=2, wdata0=4'hA.
//   -> mem_wr=1 one cycle after the IDLE sample; ack0 2 cycles after it; ram[2]=4'hA.
// - Read back: req1 read addr1=2.
//   -> mem_rd=1 for one cycle; ack1 pulse; rdata1=4'hA held after ack.
// - Simultaneous req0 and req1, reads, repeated 4 times:
//   -> grants alternate 0,1,0,1 (round-robin, port 0 first after reset).
// - Same stimulus with RAM_ARB_FIXED_PRIO_EN defined:
//   -> port 0 granted every time while req0 stays high.
// - Out-of-range: req0 write addr0=5.
//   -> mem_wr stays 0; ack0=err0=1 together; ram contents unchanged.
// - rst_n low during SERVE of a read:
//   -> state IDLE; ack, mem_rd, rdata all 0; next req0 served normally.

Source files
------------

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p
// Two-requester arbiter/sequencer in front of a small single-port RAM.
// It runs one access at a time through IDLE -> SERVE -> DONE, registers read
// data per requester and acks the granted requester with a one-cycle pulse.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0
// wins every tie). Without it, ties are broken round-robin.
module ram_arbiter_2p #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mem_wr_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_add_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              anyReq;
    logic              gntSel;
    logic              inRange;

    // Addresses at or beyond DEPTH never reach the RAM; they are flagged with err.
    assign inRange = int'(addr_q) < DEPTH;
    assign anyReq  = req0_i | req1_i;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 wins whenever it is requesting.
    always_comb begin
        gntSel = ~req0_i;
    end
`else
    logic lastGnt_q;

    // Round-robin: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        gntSel = ~req0_i;
        if (req0_i && req1_i) begin
            gntSel = ~lastGnt_q;
        end
    end

    // Remember the most recently completed grant; reset favours port 0 on the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lastGnt_q <= 1'b1;
        end else if (state_q == DONE) begin
            lastGnt_q <= gnt_q;
        end
    end
`endif

    // State register for the access sequencer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every access takes exactly one SERVE and one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anyReq) state_d = SERVE;
            SERVE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the winning request in IDLE; these registers also drive the RAM
    // address/data lines, so they hold their value between accesses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && anyReq) begin
            gnt_q   <= gntSel;
            we_q    <= gntSel ? we1_i    : we0_i;
            addr_q  <= gntSel ? addr1_i  : addr0_i;
            wdata_q <= gntSel ? wdata1_i : wdata0_i;
        end
    end

    // Read data is captured at the edge closing SERVE and held per requester
    // until that requester's next in-range read completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == SERVE && !we_q && inRange) begin
            if (gnt_q) begin
                rdata1_q <= mem_dout_i;
            end else begin
                rdata0_q <= mem_dout_i;
            end
        end
    end

    assign mem_wr_o  = (state_q == SERVE) &&  we_q && inRange;
    assign mem_rd_o  = (state_q == SERVE) && !we_q && inRange;
    assign mem_add_o = addr_q;
    assign mem_din_o = wdata_q;

    assign ack0_o   = (state_q == DONE) && !gnt_q;
    assign ack1_o   = (state_q == DONE) &&  gnt_q;
    assign err0_o   = ack0_o && !inRange;
    assign err1_o   = ack1_o && !inRange;
    assign rdata0_o = rdata0_q;
    assign rdata1_o = rdata1_q;

endmodule
